// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module      : regfile_mp_if
// Description : Read/write/dump signal bundle for the regfile_mp register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] i_raddr1;
    logic [ADDR_WIDTH-1:0] i_raddr2;
    logic [DATA_WIDTH-1:0] o_rdata1;
    logic [DATA_WIDTH-1:0] o_rdata2;
    logic [ADDR_WIDTH-1:0] i_waddr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_wen;
    logic                  i_dump_start;
    logic [DATA_WIDTH-1:0] o_dump_data;
    logic [ADDR_WIDTH-1:0] o_dump_addr;
    logic                  o_dump_valid;
    logic                  i_dump_ready;
    logic                  o_dump_busy;
    logic                  o_dump_done;

    modport slave (
        input  i_raddr1, i_raddr2, i_waddr, i_wdata, i_wen, i_dump_start, i_dump_ready,
        output o_rdata1, o_rdata2, o_dump_data, o_dump_addr, o_dump_valid, o_dump_busy,
               o_dump_done
    );

    modport master (
        output i_raddr1, i_raddr2, i_waddr, i_wdata, i_wen, i_dump_start, i_dump_ready,
        input  o_rdata1, o_rdata2, o_dump_data, o_dump_addr, o_dump_valid, o_dump_busy,
               o_dump_done
    );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : 2R/1W register file with a handshaked full-file dump stream.
//               Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  wire logic   clk,
    input  wire logic   i_rst_n,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,        ptr_d;
    logic [DATA_WIDTH-1:0] dump_data_q,  dump_data_d;
    logic [ADDR_WIDTH-1:0] dump_addr_q,  dump_addr_d;
    logic                  dump_valid_q, dump_valid_d;
    logic                  dump_busy_q,  dump_busy_d;
    logic                  dump_done_q,  dump_done_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rdata1;
    logic [DATA_WIDTH-1:0] w_rdata2;

    assign w_wr_en = bus.i_wen && !((ZERO_REG != 0) && (bus.i_waddr == '0));

    always_comb begin
        mem_d = mem_q;
        if (w_wr_en) begin
            mem_d[bus.i_waddr] = bus.i_wdata;
        end
    end

    always_comb begin
        w_rdata1 = ((ZERO_REG != 0) && (bus.i_raddr1 == '0)) ? '0 : mem_q[bus.i_raddr1];
        w_rdata2 = ((ZERO_REG != 0) && (bus.i_raddr2 == '0)) ? '0 : mem_q[bus.i_raddr2];
`ifdef REGFILE_BYPASS_EN
        // w_wr_en already excludes the hardwired zero register
        if (w_wr_en && (bus.i_waddr == bus.i_raddr1)) begin
            w_rdata1 = bus.i_wdata;
        end
        if (w_wr_en && (bus.i_waddr == bus.i_raddr2)) begin
            w_rdata2 = bus.i_wdata;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        dump_data_d  = dump_data_q;
        dump_addr_d  = dump_addr_q;
        dump_valid_d = dump_valid_q;
        dump_busy_d  = dump_busy_q;
        dump_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_dump_start) begin
                    state_d     = LOAD;
                    ptr_d       = '0;
                    dump_busy_d = 1'b1;
                end
            end
            LOAD: begin
                // Samples mem_q, so a write landing on this same edge is excluded
                dump_data_d  = ((ZERO_REG != 0) && (ptr_q == '0)) ? '0 : mem_q[ptr_q];
                dump_addr_d  = ptr_q;
                dump_valid_d = 1'b1;
                state_d      = SEND;
            end
            SEND: begin
                if (bus.i_dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (&ptr_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                dump_done_d = 1'b1;
                dump_busy_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            dump_data_q  <= '0;
            dump_addr_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            dump_done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            dump_data_q  <= dump_data_d;
            dump_addr_q  <= dump_addr_d;
            dump_valid_q <= dump_valid_d;
            dump_busy_q  <= dump_busy_d;
            dump_done_q  <= dump_done_d;
            mem_q        <= mem_d;
        end
    end

    assign bus.o_rdata1     = w_rdata1;
    assign bus.o_rdata2     = w_rdata2;
    assign bus.o_dump_data  = dump_data_q;
    assign bus.o_dump_addr  = dump_addr_q;
    assign bus.o_dump_valid = dump_valid_q;
    assign bus.o_dump_busy  = dump_busy_q;
    assign bus.o_dump_done  = dump_done_q;

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of each register in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the address width; the register file holds DEPTH = 2**ADDR_WIDTH registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning that when set to 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have ports i_raddr1 and i_raddr2, input, ADDR_WIDTH bits each: read addresses.
REQ-007 The block SHALL have ports o_rdata1 and o_rdata2, output, DATA_WIDTH bits each: combinational read data.
REQ-008 The block SHALL have ports i_waddr (ADDR_WIDTH), i_wdata (DATA_WIDTH) and i_wen (1), all inputs: the write port.
REQ-009 The block SHALL have port i_dump_start, input, 1 bit: a one-cycle request to stream out the whole file.
REQ-010 The block SHALL have ports o_dump_data (DATA_WIDTH), o_dump_addr (ADDR_WIDTH) and o_dump_valid (1), all outputs: the dump stream.
REQ-011 The block SHALL have port i_dump_ready, input, 1 bit: consumer ready for the dump stream.
REQ-012 The block SHALL have ports o_dump_busy and o_dump_done, outputs, 1 bit each: dump in progress, and a one-cycle completion pulse.

Function
REQ-013 Reads SHALL be combinational: o_rdataN = reg[i_raddrN], and 0 when ZERO_REG=1 and i_raddrN==0.
REQ-014 When i_wen=1 at a clock edge, reg[i_waddr] SHALL take i_wdata; the write SHALL be dropped when ZERO_REG=1 and i_waddr==0.
REQ-015 The dump FSM SHALL have exactly the states IDLE, LOAD, SEND and DONE.
REQ-016 In IDLE with i_dump_start=1, the FSM SHALL go to LOAD, clear the pointer to 0 and set o_dump_busy.
REQ-017 LOAD SHALL register the current reg[ptr] (0 for ptr 0 when ZERO_REG=1) into o_dump_data and ptr into o_dump_addr, then go to SEND.
REQ-018 In SEND, o_dump_valid SHALL be 1, and o_dump_data/o_dump_addr SHALL be held stable until a cycle with i_dump_ready=1.
REQ-019 On a SEND handshake with ptr<DEPTH-1, the FSM SHALL increment ptr and go to LOAD; with ptr==DEPTH-1 it SHALL go to DONE.
REQ-020 DONE SHALL assert o_dump_done for exactly one cycle, clear o_dump_busy and return to IDLE.
REQ-021 Timing: start sampled at edge N SHALL give first valid after edge N+1; each word SHALL cost at least 2 cycles; total SHALL be 2*DEPTH+1 cycles with ready held high.
REQ-022 An i_dump_start while busy SHALL be ignored.
REQ-023 Writes during a dump SHALL be allowed; each dumped word SHALL reflect the array at its LOAD cycle, including a write landing at that same edge being excluded.
REQ-024 The read and write ports SHALL be fully operational in all FSM states.

Reset
REQ-025 i_rst_n=0 SHALL asynchronously clear all registers, ptr, o_dump_data, o_dump_addr, o_dump_valid, o_dump_busy and o_dump_done to 0 and force the FSM to IDLE.
REQ-026 A reset mid-dump SHALL abort the dump with no o_dump_done pulse.
REQ-027 Writes presented while i_rst_n=0 SHALL be lost.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, when i_wen=1 and i_waddr==i_raddrN (and is not the zero register when ZERO_REG=1), o_rdataN SHALL equal i_wdata in the same cycle.
REQ-029 Without REGFILE_BYPASS_EN, reads SHALL return the pre-write array value in the cycle of the write.

Verification
REQ-030 Reset test: write 0xDEADBEEF to x5, then pulse i_rst_n low mid-cycle -> o_rdata1 for x5 SHALL be 0 immediately, asynchronously.
REQ-031 Zero-register test: ZERO_REG=1, write 0x1234 to x0 -> read x0 SHALL give 0; ZERO_REG=0 -> read x0 SHALL give 0x1234.
REQ-032 Bypass test: write 0xA5A5A5A5 to x7 while i_raddr2=7 -> o_rdata2 SHALL be 0xA5A5A5A5 that cycle with the macro, and the old value (0) without it.
REQ-033 Dump test: fill reg[i]=i*3, ready held high -> 32 words with addr 0..31 and data i*3 (x0=0); o_dump_done at cycle 65 after start.
REQ-034 Backpressure test: hold ready low for 5 cycles on word 4 -> data 12 and addr 4 SHALL stay stable, with no skipped or duplicated words.
REQ-035 Abort test: assert reset while the dump is at word 10 -> valid and busy SHALL drop to 0, and a new start SHALL restart at addr 0.
